// File: rtl/p405s_icu_fillctl.sv
// Line-fill sequencer for the 2-way ICU: requests a missed line from the PLB,
// writes beats critical-word-first into the victim way, forwards the critical beat, then updates tag/LRU.
module p405s_icu_fillctl #(
    parameter int LINE_BEATS = 4,
    parameter int BW         = 2
) (
    input  logic          CB,
    input  logic          reset,
    input  logic          missReq,
    input  logic          missCacheable,
    input  logic [BW-1:0] missBeat,
    input  logic          lruWay,
    input  logic          IFB_isAbort2,
    input  logic          plbAck,
    input  logic          plbRdDValid,
    input  logic          plbRdErr,
    output logic          plbReq,
    output logic          plbLine,
    output logic          fillBusy,
    output logic          dataWrEn,
    output logic          wrWay,
    output logic [BW-1:0] wrBeat,
    output logic          fwdValid,
    output logic          fwdErr,
    output logic          tagWrEn,
    output logic          tagValid,
    output logic          lruWrEn
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FILL  = 2'd2,
        TAGWR = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [BW-1:0] beat_cnt, beat_nxt;
    logic [BW-1:0] rcv_cnt, rcv_nxt;
    logic          nc_flag, nc_nxt;
    logic          abort_seen, abort_nxt;
    logic          err_seen, err_nxt;
    logic          way_nxt, line_nxt;
    logic          req_nxt, busy_nxt, tagwr_nxt, tagval_nxt, lru_nxt;
    logic          first_beat, last_beat;

    assign first_beat = (rcv_cnt == '0);
    assign last_beat  = (rcv_cnt == BW'(LINE_BEATS - 1));

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat_cnt;
        rcv_nxt   = rcv_cnt;
        nc_nxt    = nc_flag;
        abort_nxt = abort_seen;
        err_nxt   = err_seen;
        way_nxt   = wrWay;
        line_nxt  = plbLine;
        dataWrEn  = 1'b0;
        wrBeat    = beat_cnt;
        fwdValid  = 1'b0;
        fwdErr    = 1'b0;

        case (state)
            IDLE: begin
                if (missReq) begin
                    state_nxt = REQ;
                    nc_nxt    = ~missCacheable;
                    line_nxt  = missCacheable;
                    beat_nxt  = missBeat;
                    way_nxt   = lruWay;
                    rcv_nxt   = '0;
                    abort_nxt = 1'b0;
                    err_nxt   = 1'b0;
                end
            end
            REQ: begin
                // An ack in the same cycle as an abort wins: the bus transfer is already committed.
                if (plbAck) begin
                    state_nxt = FILL;
                    abort_nxt = IFB_isAbort2;
                end else if (IFB_isAbort2) begin
                    state_nxt = IDLE;
                end
            end
            FILL: begin
                if (IFB_isAbort2) begin
                    abort_nxt = 1'b1;
                end
                if (plbRdDValid) begin
                    dataWrEn = ~nc_flag & ~err_seen & ~plbRdErr;
                    fwdValid = first_beat & ~abort_seen & ~IFB_isAbort2;
                    fwdErr   = fwdValid & plbRdErr;
                    if (plbRdErr) begin
                        err_nxt = 1'b1;
                    end
                    beat_nxt = beat_cnt + 1'b1;
                    rcv_nxt  = rcv_cnt + 1'b1;
                    if (nc_flag) begin
                        state_nxt = IDLE;
                    end else if (last_beat) begin
                        state_nxt = TAGWR;
                    end
                end
            end
            TAGWR: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        req_nxt    = (state_nxt == REQ);
        busy_nxt   = (state_nxt != IDLE);
        tagwr_nxt  = (state_nxt == TAGWR);
        tagval_nxt = tagwr_nxt & ~err_nxt;
        lru_nxt    = tagwr_nxt & ~err_nxt;
    end

    always_ff @(posedge CB) begin
        if (reset) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            rcv_cnt    <= '0;
            nc_flag    <= 1'b0;
            abort_seen <= 1'b0;
            err_seen   <= 1'b0;
            plbReq     <= 1'b0;
            plbLine    <= 1'b0;
            fillBusy   <= 1'b0;
            wrWay      <= 1'b0;
            tagWrEn    <= 1'b0;
            tagValid   <= 1'b0;
            lruWrEn    <= 1'b0;
        end else begin
            state      <= state_nxt;
            beat_cnt   <= beat_nxt;
            rcv_cnt    <= rcv_nxt;
            nc_flag    <= nc_nxt;
            abort_seen <= abort_nxt;
            err_seen   <= err_nxt;
            plbReq     <= req_nxt;
            plbLine    <= line_nxt;
            fillBusy   <= busy_nxt;
            wrWay      <= way_nxt;
            tagWrEn    <= tagwr_nxt;
            tagValid   <= tagval_nxt;
            lruWrEn    <= lru_nxt;
        end
    end

endmodule

// File: tb/tb_p405s_icu_fillctl.sv
// Scoreboard bench for p405s_icu_fillctl: directed fills against a 4-beat and an 8-beat instance.
module tb_p405s_icu_fillctl;

    typedef struct packed {
        logic       we;
        logic       way;
        logic [2:0] beat;
        logic       fv;
        logic       fe;
        logic       tw;
        logic       tv;
        logic       lw;
    } ev_t;

    logic       CB = 1'b0;
    logic       reset = 1'b1;
    logic       miss_req = 1'b0;
    logic       miss_cache = 1'b0;
    logic [2:0] miss_beat = 3'd0;
    logic       lru_way = 1'b0;
    logic       abort = 1'b0;
    logic       plb_ack = 1'b0;
    logic       plb_dv = 1'b0;
    logic       plb_err = 1'b0;
    bit         sel8 = 1'b0;

    logic       o4_req, o4_line, o4_busy, o4_we, o4_way, o4_fv, o4_fe, o4_tw, o4_tv, o4_lw;
    logic [1:0] o4_beat;
    logic       o8_req, o8_line, o8_busy, o8_we, o8_way, o8_fv, o8_fe, o8_tw, o8_tv, o8_lw;
    logic [2:0] o8_beat;

    logic       c_req, c_line, c_busy, c_we, c_way, c_fv, c_fe, c_tw, c_tv, c_lw;
    logic [2:0] c_beat;

    ev_t exp_q[$];
    int  checks = 0;
    int  passes = 0;

    always #5 CB = ~CB;

    p405s_icu_fillctl #(.LINE_BEATS(4), .BW(2)) dut4 (
        .CB(CB), .reset(reset), .missReq(miss_req), .missCacheable(miss_cache),
        .missBeat(miss_beat[1:0]), .lruWay(lru_way), .IFB_isAbort2(abort),
        .plbAck(plb_ack), .plbRdDValid(plb_dv), .plbRdErr(plb_err),
        .plbReq(o4_req), .plbLine(o4_line), .fillBusy(o4_busy), .dataWrEn(o4_we),
        .wrWay(o4_way), .wrBeat(o4_beat), .fwdValid(o4_fv), .fwdErr(o4_fe),
        .tagWrEn(o4_tw), .tagValid(o4_tv), .lruWrEn(o4_lw)
    );

    p405s_icu_fillctl #(.LINE_BEATS(8), .BW(3)) dut8 (
        .CB(CB), .reset(reset), .missReq(miss_req), .missCacheable(miss_cache),
        .missBeat(miss_beat), .lruWay(lru_way), .IFB_isAbort2(abort),
        .plbAck(plb_ack), .plbRdDValid(plb_dv), .plbRdErr(plb_err),
        .plbReq(o8_req), .plbLine(o8_line), .fillBusy(o8_busy), .dataWrEn(o8_we),
        .wrWay(o8_way), .wrBeat(o8_beat), .fwdValid(o8_fv), .fwdErr(o8_fe),
        .tagWrEn(o8_tw), .tagValid(o8_tv), .lruWrEn(o8_lw)
    );

    always_comb begin
        if (sel8) begin
            {c_req, c_line, c_busy, c_we, c_way, c_fv, c_fe, c_tw, c_tv, c_lw} =
                {o8_req, o8_line, o8_busy, o8_we, o8_way, o8_fv, o8_fe, o8_tw, o8_tv, o8_lw};
            c_beat = o8_beat;
        end else begin
            {c_req, c_line, c_busy, c_we, c_way, c_fv, c_fe, c_tw, c_tv, c_lw} =
                {o4_req, o4_line, o4_busy, o4_we, o4_way, o4_fv, o4_fe, o4_tw, o4_tv, o4_lw};
            c_beat = {1'b0, o4_beat};
        end
    end

    // Every cycle with a write, forward or tag update must match the next expected event.
    initial begin
        ev_t obs;
        ev_t e;
        forever begin
            @(negedge CB);
            if (c_we || c_fv || c_tw) begin
                obs.we   = c_we;
                obs.way  = c_we ? c_way : 1'b0;
                obs.beat = c_we ? c_beat : 3'd0;
                obs.fv   = c_fv;
                obs.fe   = c_fv ? c_fe : 1'b0;
                obs.tw   = c_tw;
                obs.tv   = c_tw ? c_tv : 1'b0;
                obs.lw   = c_tw ? c_lw : 1'b0;
                checks++;
                if (exp_q.size() == 0) begin
                    $display("[TB] FAIL unexpected_event got=%b (we,way,beat,fv,fe,tw,tv,lw) at %0t", obs, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (obs === e) begin
                        passes++;
                    end else begin
                        $display("[TB] FAIL event got=%b want=%b (we,way,beat,fv,fe,tw,tv,lw) at %0t", obs, e, $time);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge CB);
        #1;
    endtask

    task automatic check_output(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got === want) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic void push_ev(input logic we, input logic way, input logic [2:0] beat,
                                    input logic fv, input logic fe, input logic tw,
                                    input logic tv, input logic lw);
        ev_t e;
        e = '{we: we, way: way, beat: beat, fv: fv, fe: fe, tw: tw, tv: tv, lw: lw};
        exp_q.push_back(e);
    endfunction

    task automatic do_miss(input logic c, input logic [2:0] b, input logic w);
        miss_req   = 1'b1;
        miss_cache = c;
        miss_beat  = b;
        lru_way    = w;
        tick();
        miss_req = 1'b0;
        check_output("req_after_miss", {7'd0, c_req}, 8'd1);
        check_output("busy_after_miss", {7'd0, c_busy}, 8'd1);
        check_output("plbline", {7'd0, c_line}, {7'd0, c});
    endtask

    task automatic do_ack();
        plb_ack = 1'b1;
        tick();
        plb_ack = 1'b0;
        check_output("req_after_ack", {7'd0, c_req}, 8'd0);
    endtask

    task automatic do_beats(input int n, input logic [7:0] err_mask, input bit gap);
        for (int i = 0; i < n; i++) begin
            plb_dv  = 1'b1;
            plb_err = err_mask[i];
            tick();
            plb_dv  = 1'b0;
            plb_err = 1'b0;
            if (gap) tick();
        end
    endtask

    initial begin
        tick();
        tick();
        check_output("reset_req", {7'd0, c_req}, 8'd0);
        check_output("reset_busy", {7'd0, c_busy}, 8'd0);
        check_output("reset_tag", {7'd0, c_tw}, 8'd0);
        check_output("reset_line", {7'd0, c_line}, 8'd0);
        reset = 1'b0;
        tick();

        // Cacheable fill from beat 2 into way B, ack after three cycles.
        do_miss(1'b1, 3'd2, 1'b1);
        tick();
        tick();
        check_output("req_held", {7'd0, c_req}, 8'd1);
        do_ack();
        push_ev(1, 1, 3'd2, 1, 0, 0, 0, 0);
        push_ev(1, 1, 3'd3, 0, 0, 0, 0, 0);
        push_ev(1, 1, 3'd0, 0, 0, 0, 0, 0);
        push_ev(1, 1, 3'd1, 0, 0, 0, 0, 0);
        push_ev(0, 0, 3'd0, 0, 0, 1, 1, 1);
        do_beats(4, 8'h00, 1'b0);
        tick();
        check_output("busy_after_tag", {7'd0, c_busy}, 8'd0);

        // Non-cacheable single beat.
        do_miss(1'b0, 3'd1, 1'b0);
        do_ack();
        push_ev(0, 0, 3'd0, 1, 0, 0, 0, 0);
        do_beats(1, 8'h00, 1'b0);
        check_output("busy_after_nc", {7'd0, c_busy}, 8'd0);
        tick();

        // Abort before ack withdraws the request.
        do_miss(1'b1, 3'd0, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_output("req_after_abort", {7'd0, c_req}, 8'd0);
        check_output("busy_after_abort", {7'd0, c_busy}, 8'd0);
        tick();

        // Abort in FILL before beat 0: line still written and tagged, nothing forwarded.
        do_miss(1'b1, 3'd0, 1'b0);
        do_ack();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int i = 0; i < 4; i++) push_ev(1, 0, 3'(i), 0, 0, 0, 0, 0);
        push_ev(0, 0, 3'd0, 0, 0, 1, 1, 1);
        do_beats(4, 8'h00, 1'b0);
        tick();

        // Error on beat 1: only beat 0 written, tag invalidated, no LRU update.
        do_miss(1'b1, 3'd0, 1'b1);
        do_ack();
        push_ev(1, 1, 3'd0, 1, 0, 0, 0, 0);
        push_ev(0, 0, 3'd0, 0, 0, 1, 0, 0);
        do_beats(4, 8'h02, 1'b0);
        tick();
        check_output("busy_after_err", {7'd0, c_busy}, 8'd0);

        // Error on the critical beat is forwarded with fwdErr.
        do_miss(1'b1, 3'd3, 1'b0);
        do_ack();
        push_ev(0, 0, 3'd0, 1, 1, 0, 0, 0);
        push_ev(0, 0, 3'd0, 0, 0, 1, 0, 0);
        do_beats(4, 8'h01, 1'b0);
        tick();

        // Reset after two beats abandons the fill; a new miss fills cleanly.
        do_miss(1'b1, 3'd1, 1'b1);
        do_ack();
        push_ev(1, 1, 3'd1, 1, 0, 0, 0, 0);
        push_ev(1, 1, 3'd2, 0, 0, 0, 0, 0);
        do_beats(2, 8'h00, 1'b0);
        reset = 1'b1;
        tick();
        check_output("midfill_reset_busy", {7'd0, c_busy}, 8'd0);
        check_output("midfill_reset_req", {7'd0, c_req}, 8'd0);
        check_output("midfill_reset_way", {7'd0, c_way}, 8'd0);
        check_output("midfill_reset_tag", {7'd0, c_tw}, 8'd0);
        reset = 1'b0;
        tick();
        tick();
        do_miss(1'b1, 3'd0, 1'b0);
        do_ack();
        for (int i = 0; i < 4; i++) push_ev(1, 0, 3'(i), (i == 0), 0, 0, 0, 0);
        push_ev(0, 0, 3'd0, 0, 0, 1, 1, 1);
        do_beats(4, 8'h00, 1'b0);
        tick();

        // 8-beat line starting at beat 7 with idle gaps between beats.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sel8 = 1'b1;
        tick();
        do_miss(1'b1, 3'd7, 1'b1);
        do_ack();
        push_ev(1, 1, 3'd7, 1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) push_ev(1, 1, 3'(i), 0, 0, 0, 0, 0);
        push_ev(0, 0, 3'd0, 0, 0, 1, 1, 1);
        do_beats(7, 8'h00, 1'b1);
        check_output("busy_before_beat8", {7'd0, c_busy}, 8'd1);
        check_output("no_tag_before_beat8", {7'd0, c_tw}, 8'd0);
        do_beats(1, 8'h00, 1'b0);
        tick();
        check_output("busy_after_8beat", {7'd0, c_busy}, 8'd0);
        tick();
        tick();

        checks++;
        if (exp_q.size() == 0) begin
            passes++;
        end else begin
            $display("[TB] FAIL missing_events got=%0d want=0 pending", exp_q.size());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
